// File: rtl/alu_logical_pipe.sv
// Registered logical ALU with accumulator, valid/ready handshake, Z/P flags and a
// saturating accepted-op counter. Define ALU_LOGICAL_ROTATE_EN to turn op 011 into ROTL.
module alu_logical_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             inv,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] f,
  output logic             flag_z,
  output logic             flag_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_XOR     = 3'b010,
    OP_PASS    = 3'b011,
    OP_ZERO    = 3'b100,
    OP_ACC_AND = 3'b101,
    OP_ACC_OR  = 3'b110,
    OP_ACC_XOR = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             accept;

  // One-deep output register: a slot frees up whenever the current result drains.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_eff  = acc_clr ? '0 : acc_q;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    raw = '0;
    unique case (op_e'(op))
      OP_AND:     raw = a & b;
      OP_OR:      raw = a | b;
      OP_XOR:     raw = a ^ b;
`ifdef ALU_LOGICAL_ROTATE_EN
      OP_PASS:    raw = {a[WIDTH-2:0], a[WIDTH-1]};
`else
      OP_PASS:    raw = a;
`endif
      OP_ZERO:    raw = '0;
      OP_ACC_AND: raw = a & acc_eff;
      OP_ACC_OR:  raw = a | acc_eff;
      OP_ACC_XOR: raw = a ^ acc_eff;
      default:    raw = '0;
    endcase
    res = inv ? ~raw : raw;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      f         <= '0;
      flag_z    <= 1'b1;
      flag_p    <= 1'b0;
      out_valid <= 1'b0;
      acc_q     <= '0;
      op_count  <= '0;
    end else if (accept) begin
      f         <= res;
      flag_z    <= (res == '0);
      flag_p    <= ^res;
      out_valid <= 1'b1;
      acc_q     <= res;
      if (op_count != '1) op_count <= op_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_logical_pipe.sv
// Scoreboard bench for alu_logical_pipe (WIDTH=8, CNT_W=2 so op_count saturation is reachable).
module tb_alu_logical_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             inv;
  logic             acc_clr;
  logic [WIDTH-1:0] f;
  logic             flag_z;
  logic             flag_p;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;

  alu_logical_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .inv(inv), .acc_clr(acc_clr),
    .f(f), .flag_z(flag_z), .flag_p(flag_p),
    .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_acc = '0;
  int               m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic [2:0] mop, input logic minv,
                                             input logic mclr, input logic [WIDTH-1:0] macc);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] r;
    x = mclr ? '0 : macc;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma ^ mb;
`ifdef ALU_LOGICAL_ROTATE_EN
      3'd3: r = {ma[WIDTH-2:0], ma[WIDTH-1]};
`else
      3'd3: r = ma;
`endif
      3'd4: r = '0;
      3'd5: r = ma & x;
      3'd6: r = ma | x;
      default: r = ma ^ x;
    endcase
    return minv ? ~r : r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                       input logic [2:0] dop, input logic dinv, input logic dclr);
    in_valid = v; a = da; b = db; op = dop; inv = dinv; acc_clr = dclr;
  endtask

  // Called just after a falling edge with inputs already set; returns after the next falling edge.
  task automatic step(input bit has_exp = 1'b0, input logic [WIDTH-1:0] exp = '0);
    logic             m_rdy;
    logic [WIDTH-1:0] r;
    #1;
    m_rdy = (exp_q.size() == 0) || out_ready;
    check("in_ready", in_ready, m_rdy);
    if (!rst) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("f", f, exp_q[0]);
        check("flag_z", flag_z, exp_q[0] == '0);
        check("flag_p", flag_p, ^exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && m_rdy) begin
        r = has_exp ? exp : model(a, b, op, inv, acc_clr, m_acc);
        exp_q.push_back(r);
        m_acc = r;
        if (m_cnt != CNT_MAX) m_cnt++;
      end
    end
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_acc = '0;
      m_cnt = 0;
      check("rst_f", f, 0);
      check("rst_z", flag_z, 1);
      check("rst_p", flag_p, 0);
      check("rst_valid", out_valid, 0);
    end
    check("op_count", op_count, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] sat_tbl [5];
    sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0);
    @(negedge clk);
    do_reset();

    // Basic ops, one per cycle
    drive(1, 8'hA8, 8'hD5, 3'd0, 0, 0); step(1, 8'h80);
    drive(1, 8'hA8, 8'hD5, 3'd1, 0, 0); step(1, 8'hFD);
    drive(1, 8'hA8, 8'hD5, 3'd2, 0, 0); step(1, 8'h7D);
    drive(1, 8'h00, 8'hFF, 3'd0, 1, 0); step(1, 8'hFF);
    drive(1, 8'h00, 8'hFF, 3'd4, 0, 0); step(1, 8'h00);
    drive(1, 8'h00, 8'hFF, 3'd4, 1, 0); step(1, 8'hFF);

    // Accumulator chain, including a clear that arrives without an accept
    drive(1, 8'h0F, 8'h00, 3'd6, 0, 1); step(1, 8'h0F);
    drive(1, 8'hFF, 8'h00, 3'd7, 0, 0); step(1, 8'hF0);
    drive(1, 8'h30, 8'h00, 3'd5, 0, 0); step(1, 8'h30);
    drive(0, 8'h00, 8'h00, 3'd6, 0, 1); step();
    drive(1, 8'h01, 8'h00, 3'd6, 0, 0); step(1, 8'h31);

    // Saturating counter
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0); step();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h5A, 8'hC3, 3'd2, 0, 0);
      step(1, 8'h99);
      check("sat_count", op_count, sat_tbl[i]);
    end

    // Reset while a result is pending and a new op is offered
    rst = 1'b1; drive(1, 8'hFF, 8'hFF, 3'd1, 0, 0); step(); rst = 1'b0;
    drive(1, 8'h00, 8'h00, 3'd6, 0, 0); step(1, 8'h00);
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0); step();

    // Backpressure: three stalled cycles, then release
    do_reset();
    drive(1, 8'hA8, 8'hD5, 3'd0, 0, 0); step(1, 8'h80);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h0F + 8'(i), 8'hF0, 3'd1, 0, 0);
      step();
      check("bp_count", op_count, 1);
    end
    drive(1, 8'h0F, 8'hF0, 3'd1, 0, 0);
    out_ready = 1'b1;
    step(1, 8'hFF);
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0); step();

    // Opcode 011 (PASS or ROTL depending on the build)
`ifdef ALU_LOGICAL_ROTATE_EN
    drive(1, 8'hA8, 8'h00, 3'd3, 0, 0); step(1, 8'h51);
`else
    drive(1, 8'hA8, 8'h00, 3'd3, 0, 0); step(1, 8'hA8);
`endif

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) == 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    // Drain
    drive(0, 8'h00, 8'h00, 3'd0, 0, 0);
    out_ready = 1'b1;
    step();
    step();
    check("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
